// File: rtl/mips_ctrl_fsm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mips_ctrl_fsm_pkg
// Purpose  : Shared definitions for the multicycle MIPS control FSM:
//            opcode and funct constants, 4-bit state encodings, ALU
//            operation selectors, alucont codes, the control-word struct,
//            and the state-to-control / next-state helper functions.
// Revision : 1.0 - initial release
// ============================================================================
package mips_ctrl_fsm_pkg;

   // Opcodes (instr[31:26])
   localparam logic [5:0] c_OP_RTYPE = 6'b000000;
   localparam logic [5:0] c_OP_J     = 6'b000010;
   localparam logic [5:0] c_OP_BEQ   = 6'b000100;
   localparam logic [5:0] c_OP_ADDI  = 6'b001000;
   localparam logic [5:0] c_OP_LB    = 6'b100000;
   localparam logic [5:0] c_OP_SB    = 6'b101000;

   // R-type function codes (instr[5:0])
   localparam logic [5:0] c_FN_ADD = 6'b100000;
   localparam logic [5:0] c_FN_SUB = 6'b100010;
   localparam logic [5:0] c_FN_AND = 6'b100100;
   localparam logic [5:0] c_FN_OR  = 6'b100101;
   localparam logic [5:0] c_FN_SLT = 6'b101010;

   // alucont codes presented to the datapath ALU
   localparam logic [2:0] c_ALU_AND = 3'b000;
   localparam logic [2:0] c_ALU_OR  = 3'b001;
   localparam logic [2:0] c_ALU_ADD = 3'b010;
   localparam logic [2:0] c_ALU_SUB = 3'b110;
   localparam logic [2:0] c_ALU_SLT = 3'b111;

   // FSM state encodings; 4'hF is unused and recovers to S_FETCH1
   typedef enum logic [3:0] {
      S_FETCH1  = 4'd0,
      S_FETCH2  = 4'd1,
      S_FETCH3  = 4'd2,
      S_FETCH4  = 4'd3,
      S_DECODE  = 4'd4,
      S_MEMADR  = 4'd5,
      S_LBRD    = 4'd6,
      S_LBWR    = 4'd7,
      S_SBWR    = 4'd8,
      S_RTYPEEX = 4'd9,
      S_RTYPEWR = 4'd10,
      S_BEQEX   = 4'd11,
      S_JEX     = 4'd12,
      S_ADDIEX  = 4'd13,
      S_ADDIWR  = 4'd14
   } state_t;

   // ALU operation requested by the current state
   typedef enum logic [1:0] {
      ALUOP_ADD   = 2'b00,
      ALUOP_SUB   = 2'b01,
      ALUOP_FUNCT = 2'b10
   } aluop_t;

   // Per-state control word (everything except pcen and alucont)
   typedef struct packed {
      logic       alusrca;
      logic       memtoreg;
      logic       iord;
      logic       pcwrite;
      logic       pcwritecond;
      logic       regwrite;
      logic       regdst;
      logic [1:0] pcsource;
      logic [1:0] alusrcb;
      logic [3:0] irwrite;
      aluop_t     aluop;
      logic       memread;
      logic       memwrite;
      logic       done;
   } ctrl_t;

   // Moore decode: control word presented while the FSM sits in state s
   function automatic ctrl_t state_decode(input state_t s);
      ctrl_t c;
      c       = '0;
      c.aluop = ALUOP_ADD;
      case (s)
         S_FETCH1, S_FETCH2, S_FETCH3, S_FETCH4: begin
            c.memread = 1'b1;
            c.alusrcb = 2'b01;
            c.pcwrite = 1'b1;
            case (s)
               S_FETCH1: c.irwrite = 4'b0001;
               S_FETCH2: c.irwrite = 4'b0010;
               S_FETCH3: c.irwrite = 4'b0100;
               default:  c.irwrite = 4'b1000;
            endcase
         end
         S_DECODE: begin
            // precompute the branch target into aluout
            c.alusrcb = 2'b11;
         end
         S_MEMADR, S_ADDIEX: begin
            c.alusrca = 1'b1;
            c.alusrcb = 2'b10;
         end
         S_LBRD: begin
            c.memread = 1'b1;
            c.iord    = 1'b1;
         end
         S_LBWR: begin
            c.regwrite = 1'b1;
            c.memtoreg = 1'b1;
            c.done     = 1'b1;
         end
         S_SBWR: begin
            c.memwrite = 1'b1;
            c.iord     = 1'b1;
            c.done     = 1'b1;
         end
         S_RTYPEEX: begin
            c.alusrca = 1'b1;
            c.aluop   = ALUOP_FUNCT;
         end
         S_RTYPEWR: begin
            c.regwrite = 1'b1;
            c.regdst   = 1'b1;
            c.done     = 1'b1;
         end
         S_ADDIWR: begin
            c.regwrite = 1'b1;
            c.done     = 1'b1;
         end
         S_BEQEX: begin
            c.alusrca     = 1'b1;
            c.aluop       = ALUOP_SUB;
            c.pcsource    = 2'b01;
            c.pcwritecond = 1'b1;
            c.done        = 1'b1;
         end
         S_JEX: begin
            c.pcsource = 2'b10;
            c.pcwrite  = 1'b1;
            c.done     = 1'b1;
         end
         default: c = '0;
      endcase
      return c;
   endfunction

   // Next-state function
   function automatic state_t next_state(input state_t s, input logic [5:0] op);
      state_t n;
      n = S_FETCH1;
      case (s)
         S_FETCH1:  n = S_FETCH2;
         S_FETCH2:  n = S_FETCH3;
         S_FETCH3:  n = S_FETCH4;
         S_FETCH4:  n = S_DECODE;
         S_DECODE: begin
            case (op)
               c_OP_LB, c_OP_SB: n = S_MEMADR;
               c_OP_RTYPE:       n = S_RTYPEEX;
               c_OP_BEQ:         n = S_BEQEX;
               c_OP_J:           n = S_JEX;
               c_OP_ADDI:        n = S_ADDIEX;
               default:          n = S_FETCH1;
            endcase
         end
         S_MEMADR:  n = (op == c_OP_LB) ? S_LBRD : S_SBWR;
         S_LBRD:    n = S_LBWR;
         S_RTYPEEX: n = S_RTYPEWR;
         S_ADDIEX:  n = S_ADDIWR;
         default:   n = S_FETCH1;
      endcase
      return n;
   endfunction

endpackage
`default_nettype wire

// File: rtl/mips_ctrl_fsm_alu_decoder.sv
`default_nettype none
// ============================================================================
// Module   : alu_decoder
// Purpose  : Combinational map from the requested ALU operation (and the
//            R-type funct field) to the 3-bit alucont code.
// Ports    : i_aluop   - operation requested by the FSM state
//            i_funct   - instr[5:0], used only for function-decoded ops
//            o_alucont - ALU control code
// Revision : 1.0 - initial release
// ============================================================================
module alu_decoder
   import mips_ctrl_fsm_pkg::*;
(
   input  aluop_t     i_aluop,
   input  logic [5:0] i_funct,
   output logic [2:0] o_alucont
);

   always_comb begin
      o_alucont = c_ALU_ADD;
      case (i_aluop)
         ALUOP_ADD: o_alucont = c_ALU_ADD;
         ALUOP_SUB: o_alucont = c_ALU_SUB;
         ALUOP_FUNCT: begin
            case (i_funct)
               c_FN_ADD: o_alucont = c_ALU_ADD;
               c_FN_SUB: o_alucont = c_ALU_SUB;
               c_FN_AND: o_alucont = c_ALU_AND;
               c_FN_OR:  o_alucont = c_ALU_OR;
               c_FN_SLT: o_alucont = c_ALU_SLT;
               default:  o_alucont = c_ALU_ADD;
            endcase
         end
         default: o_alucont = c_ALU_ADD;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/mips_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module   : mips_ctrl_fsm
// Purpose  : Moore control FSM for a multicycle MIPS subset (lb, sb,
//            R-type, beq, j, addi) with a 4-byte serial instruction fetch.
// Ports    : clk, reset (async, active-low)
//            op, funct, zero           - from the datapath
//            alusrca, memtoreg, iord, pcen, regwrite, regdst,
//            pcsource, alusrcb, irwrite, alucont - datapath controls
//            memread, memwrite         - byte-memory strobes
//            done                      - pulse in each instruction's last state
// Revision : 1.0 - initial release
// ============================================================================
module mips_ctrl_fsm
   import mips_ctrl_fsm_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] op,
   input  logic [5:0] funct,
   input  logic       zero,
   output logic       alusrca,
   output logic       memtoreg,
   output logic       iord,
   output logic       pcen,
   output logic       regwrite,
   output logic       regdst,
   output logic [1:0] pcsource,
   output logic [1:0] alusrcb,
   output logic [3:0] irwrite,
   output logic [2:0] alucont,
   output logic       memread,
   output logic       memwrite,
   output logic       done
);

   state_t r_state;
   ctrl_t  r_ctrl;
   state_t w_next;

   assign w_next = next_state(r_state, op);

   // The control word is registered alongside the state, decoded from the
   // next state, so outputs are glitch-free and always equal the decode of
   // r_state. Reset loads the FETCH1 decode so outputs are valid in reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_FETCH1;
         r_ctrl  <= state_decode(S_FETCH1);
      end else begin
         r_state <= w_next;
         r_ctrl  <= state_decode(w_next);
      end
   end

   alu_decoder u_alu_decoder (
      .i_aluop   (r_ctrl.aluop),
      .i_funct   (funct),
      .o_alucont (alucont)
   );

   // Branch-taken write of the PC depends on the live zero flag
   assign pcen     = r_ctrl.pcwrite | (r_ctrl.pcwritecond & zero);

   assign alusrca  = r_ctrl.alusrca;
   assign memtoreg = r_ctrl.memtoreg;
   assign iord     = r_ctrl.iord;
   assign regwrite = r_ctrl.regwrite;
   assign regdst   = r_ctrl.regdst;
   assign pcsource = r_ctrl.pcsource;
   assign alusrcb  = r_ctrl.alusrcb;
   assign irwrite  = r_ctrl.irwrite;
   assign memread  = r_ctrl.memread;
   assign memwrite = r_ctrl.memwrite;
   assign done     = r_ctrl.done;

endmodule
`default_nettype wire

// File: doc/mips_ctrl_fsm.md
MIPS_CTRL_FSM -- requirements
Module: mips_ctrl_fsm

Interface
REQ-001 SHALL have no parameters.
REQ-002 SHALL have the port `clk`: input, 1 bit. Single clock; all state updates on the rising edge.
REQ-003 SHALL have the port `reset`: input, 1 bit. Asynchronous, active-low reset.
REQ-004 SHALL have the port `op`: input, 6 bits. Opcode, taken from datapath instr[31:26].
REQ-005 SHALL have the port `funct`: input, 6 bits. Function field, taken from datapath instr[5:0].
REQ-006 SHALL have the port `zero`: input, 1 bit. ALU-result-is-zero flag from the datapath.
REQ-007 SHALL have the control outputs `alusrca`, `memtoreg`, `iord`, `pcen`, `regwrite` and `regdst`: output, 1 bit each. They drive the datapath controls of the same names.
REQ-008 SHALL have the control outputs `pcsource` and `alusrcb`: output, 2 bits each. `irwrite`: output, 4 bits. `alucont`: output, 3 bits.
REQ-009 SHALL have the outputs `memread` and `memwrite`: output, 1 bit each. Byte-memory strobes.
REQ-010 SHALL have the output `done`: output, 1 bit. One-cycle pulse in the final state of each instruction.

Function
REQ-011 SHALL be a Moore FSM. All outputs are decoded from the state register only, except `pcen` and `alucont`. Any output not listed for a state is 0.
REQ-012 SHALL implement these states and transitions:
- FETCH1 -> FETCH2 -> FETCH3 -> FETCH4 -> DECODE, unconditionally.
- From DECODE, by `op`:
  - 100000 (lb) or 101000 (sb) -> MEMADR
  - 000000 (R-type) -> RTYPEEX
  - 000100 (beq) -> BEQEX
  - 000010 (j) -> JEX
  - 001000 (addi) -> ADDIEX
  - any other value -> FETCH1
- MEMADR -> LBRD if op = lb, otherwise -> SBWR.
- LBRD -> LBWR; RTYPEEX -> RTYPEWR; ADDIEX -> ADDIWR.
- LBWR, SBWR, RTYPEWR, BEQEX, JEX and ADDIWR each -> FETCH1.
REQ-013 SHALL drive FETCHn (n = 1..4) as follows: memread = 1, iord = 0, alusrca = 0, alusrcb = 01, ALU add, pcsource = 00, pcwrite = 1, and irwrite = one-hot bit n-1 (0001, 0010, 0100, 1000).
REQ-014 SHALL drive DECODE as: alusrca = 0, alusrcb = 11, ALU add. This precomputes the branch target into aluout.
REQ-015 SHALL drive MEMADR and ADDIEX as: alusrca = 1, alusrcb = 10, ALU add.
REQ-016 SHALL drive the memory and write-back states as follows:
- LBRD: memread = 1, iord = 1.
- LBWR: regwrite = 1, memtoreg = 1, regdst = 0.
- SBWR: memwrite = 1, iord = 1.
REQ-017 SHALL drive the R-type states as follows:
- RTYPEEX: alusrca = 1, alusrcb = 00, ALU op from `funct`.
- RTYPEWR: regwrite = 1, regdst = 1, memtoreg = 0.
REQ-018 SHALL drive the remaining states as follows:
- ADDIWR: regwrite = 1, regdst = 0, memtoreg = 0.
- BEQEX: alusrca = 1, alusrcb = 00, ALU sub, pcsource = 01, pcwritecond = 1.
- JEX: pcsource = 10, pcwrite = 1.
REQ-019 SHALL compute pcen combinationally as pcwrite OR (pcwritecond AND zero).
REQ-020 SHALL map ALU operations to `alucont` as follows:
- add = 010, sub = 110.
- Function-decoded (R-type): funct 100000 -> 010, 100010 -> 110, 100100 -> 000, 100101 -> 001, 101010 -> 111.
- Any other funct value -> 010.
REQ-021 SHALL use these latencies in cycles, counted from FETCH1: lb 8, sb 7, R-type 7, addi 7, beq 6, j 6, illegal opcode 5 (no writes).
REQ-022 SHALL assert `done` in LBWR, SBWR, RTYPEWR, ADDIWR, BEQEX and JEX only. `done` is not asserted for an illegal opcode.
REQ-023 SHALL never assert regwrite, memwrite or irwrite in any unlisted state. An unencoded state value SHALL transition to FETCH1.

Reset
REQ-024 SHALL force the state register to FETCH1 asynchronously while `reset` = 0, at any point in any instruction.
REQ-025 SHALL present the FETCH1 output decode on all outputs during reset (pcen = 1, irwrite = 0001, memread = 1, done = 0). The datapath PC reset takes priority over this.
REQ-026 SHALL enter FETCH2 on the first rising edge after `reset` deasserts.

Structure
REQ-027 SHALL place the opcode constants, funct constants, state encodings (4-bit) and alucont codes in a shared package.
REQ-028 SHALL implement the funct/ALU-op to alucont decode as one combinational sub-module, `alu_decoder`.

Verification
REQ-029 SHALL cover addi, op = 001000: states F1..F4, DECODE, ADDIEX, ADDIWR. Cycle 6 has alucont = 010 and alusrcb = 10. Cycle 7 has regwrite = 1, regdst = 0 and done = 1.
REQ-030 SHALL cover R-type sub, funct = 100010: RTYPEEX has alucont = 110. RTYPEWR has regdst = 1. Also funct = 101010 -> alucont = 111.
REQ-031 SHALL cover beq:
- zero = 1 in BEQEX -> pcen = 1, pcsource = 01.
- zero = 0 -> pcen = 0; next state is FETCH1.
REQ-032 SHALL cover lb and sb:
- lb: LBRD has memread = 1, iord = 1; LBWR has memtoreg = 1. Total 8 cycles.
- sb: SBWR has memwrite = 1. Total 7 cycles.
REQ-033 SHALL cover an illegal opcode, op = 111111: DECODE -> FETCH1. No regwrite, memwrite or done is asserted.
REQ-034 SHALL cover reset: `reset` driven 0 mid-RTYPEEX -> FETCH1 immediately. After release, irwrite goes 0001 -> 0010 on successive cycles.
